// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples an external bit clock, assembles left/right
// words MSB-first and hands complete stereo pairs out on a valid/ready port.
module i2s_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  I2S_CLK,
    input  logic                  I2S_WS,
    input  logic                  I2S_DATA,
    input  logic                  Enable,
    output logic [DATA_WIDTH-1:0] SampleLeft,
    output logic [DATA_WIDTH-1:0] SampleRight,
    output logic                  SampleValid,
    input  logic                  SampleReady,
    output logic                  Overrun,
    input  logic                  OverrunClear
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {S_DISABLED, S_ALIGN, S_RUN} state_t;

    state_t                r_state, w_state_nxt;
    logic [2:0]            r_clk_s;
    logic [1:0]            r_ws_s, r_dat_s;
    logic                  r_ws_d;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shreg, r_left, r_pair_l, r_pair_r, r_out_l, r_out_r;
    logic                  r_left_pend, r_pair_stb, r_valid, r_overrun;

    logic                  w_edge, w_ws, w_bit, w_track, w_done, w_sat;
    logic                  w_latch_left, w_pair, w_accept, w_ovr_set;
    logic [CW-1:0]         w_pos;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_edge  = r_clk_s[1] & ~r_clk_s[2];
    assign w_ws    = r_ws_s[1];
    assign w_bit   = r_dat_s[1];
    assign w_track = Enable && (r_state != S_DISABLED);
    assign w_done  = w_edge && (w_ws != r_ws_d);
    assign w_sat   = (r_cnt >= CW'(DATA_WIDTH));
    assign w_pos   = CW'(DATA_WIDTH - 1) - r_cnt;
    // Word including the bit on the current edge; slot bits past DATA_WIDTH are ignored.
    assign w_word  = w_sat ? r_shreg
                           : (r_shreg | ({{(DATA_WIDTH-1){1'b0}}, w_bit} << w_pos));

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_clk_s <= '0;
            r_ws_s  <= '0;
            r_dat_s <= '0;
            r_ws_d  <= 1'b0;
            r_cnt   <= '0;
            r_shreg <= '0;
        end else begin
            r_clk_s <= {r_clk_s[1:0], I2S_CLK};
            r_ws_s  <= {r_ws_s[0], I2S_WS};
            r_dat_s <= {r_dat_s[0], I2S_DATA};
            if (w_edge)
                r_ws_d <= w_ws;
            if (!w_track) begin
                r_cnt   <= '0;
                r_shreg <= '0;
            end else if (w_edge) begin
                if (w_done) begin
                    r_cnt   <= '0;
                    r_shreg <= '0;
                end else if (!w_sat) begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_shreg <= w_word;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= S_DISABLED;
        else       r_state <= w_state_nxt;
    end

    // A completing word belongs to the channel of the previous WS (one-bit I2S delay).
    always_comb begin
        w_state_nxt  = r_state;
        w_latch_left = 1'b0;
        w_pair       = 1'b0;
        if (!Enable) begin
            w_state_nxt = S_DISABLED;
        end else begin
            case (r_state)
                S_DISABLED: w_state_nxt = S_ALIGN;
                S_ALIGN:    if (w_done && r_ws_d) w_state_nxt = S_RUN;
                S_RUN: begin
                    w_latch_left = w_done && !r_ws_d;
                    w_pair       = w_done && r_ws_d && r_left_pend;
                end
                default:    w_state_nxt = S_DISABLED;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_left      <= '0;
            r_left_pend <= 1'b0;
            r_pair_l    <= '0;
            r_pair_r    <= '0;
            r_pair_stb  <= 1'b0;
        end else begin
            r_pair_stb <= w_pair;
            if (!Enable) begin
                r_left_pend <= 1'b0;
            end else if (w_latch_left) begin
                r_left      <= w_word;
                r_left_pend <= 1'b1;
            end else if (w_pair) begin
                r_pair_l    <= r_left;
                r_pair_r    <= w_word;
                r_left_pend <= 1'b0;
            end
        end
    end

    assign w_accept  = r_valid && SampleReady;
    assign w_ovr_set = Enable && r_pair_stb && r_valid && !SampleReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (!Enable) begin
                r_valid <= 1'b0;
            end else if (r_pair_stb) begin
                // Load only if the slot is free or being emptied this cycle.
                if (!r_valid || SampleReady) begin
                    r_out_l <= r_pair_l;
                    r_out_r <= r_pair_r;
                    r_valid <= 1'b1;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_ovr_set)         r_overrun <= 1'b1;
            else if (OverrunClear) r_overrun <= 1'b0;
        end
    end

    assign SampleLeft  = r_out_l;
    assign SampleRight = r_out_r;
    assign SampleValid = r_valid;
    assign Overrun     = r_overrun;
endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: vector table, randomized frames against a
// stream-level reference model, and hand sequences for handshake corners.
module tb_i2s_rx;
    localparam int DW = 16;
    localparam int H  = 2;   // I2S_CLK half period in CLK cycles (minimum supported)

    logic          CLK = 0, Reset = 1, I2S_CLK = 0, I2S_WS = 0, I2S_DATA = 0;
    logic          Enable = 0, SampleReady = 0, OverrunClear = 0;
    logic [DW-1:0] SampleLeft, SampleRight;
    logic          SampleValid, Overrun;

    int checks = 0, errors = 0, cyc = 0, last_e0 = 0;
    bit mon_en = 0, rdone = 0;
    logic prev_v = 0;

    typedef struct {bit ch; bit d;} sbit_t;
    typedef struct {logic [15:0] l; logic [15:0] r;} pair_t;
    typedef struct {int slot; logic [31:0] l; logic [31:0] r; logic [15:0] el; logic [15:0] er;} vec_t;

    sbit_t sq[$];
    pair_t exp_q[$];
    int    rise_q[$];
    int    rcomp_q[$];
    vec_t  vt[6];

    i2s_rx #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .Reset(Reset), .I2S_CLK(I2S_CLK), .I2S_WS(I2S_WS), .I2S_DATA(I2S_DATA),
        .Enable(Enable), .SampleLeft(SampleLeft), .SampleRight(SampleRight),
        .SampleValid(SampleValid), .SampleReady(SampleReady),
        .Overrun(Overrun), .OverrunClear(OverrunClear)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Left-justified top DW bits of a slot-bit word.
    function automatic logic [15:0] top16(input logic [31:0] v, input int slot);
        logic [63:0] x;
        x = {32'b0, v} & ((64'd1 << slot) - 64'd1);
        if (slot >= 16) x = x >> (slot - 16);
        else            x = x << (16 - slot);
        return x[15:0];
    endfunction

    task automatic push_word(input bit ch, input logic [31:0] v, input int slot);
        for (int i = slot - 1; i >= 0; i--) sq.push_back('{ch, v[i]});
    endtask

    task automatic push_frame(input logic [31:0] l, input logic [31:0] r, input int slot);
        push_word(1'b0, l, slot);
        push_word(1'b1, r, slot);
    endtask

    // WS leads the data by one bit; after the stream WS is left so the last right word completes.
    task automatic play();
        for (int k = 0; k < sq.size(); k++) begin
            I2S_CLK  = 0;
            I2S_DATA = sq[k].d;
            I2S_WS   = (k + 1 < sq.size()) ? sq[k+1].ch : 1'b0;
            repeat (H) tick();
            I2S_CLK = 1;
            if (sq[k].ch && !I2S_WS) begin
                last_e0 = cyc + 1;
                rcomp_q.push_back(cyc + 1);
            end
            repeat (H) tick();
        end
        I2S_CLK = 0;
        sq.delete();
    endtask

    task automatic do_reset();
        mon_en = 0;
        exp_q.delete();
        Reset = 1;
        repeat (2) tick();
        Reset = 0;
        tick();
    endtask

    task automatic settle_empty(input string name);
        repeat (8) tick();
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge CLK) begin
        if (SampleValid && !prev_v) rise_q.push_back(cyc);
        prev_v = SampleValid;
        if (mon_en && !Reset && SampleValid && SampleReady) begin
            pair_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got %0h/%0h expected none", SampleLeft, SampleRight);
            end else begin
                e = exp_q.pop_front();
                check("pair_left", SampleLeft, e.l);
                check("pair_right", SampleRight, e.r);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32, 32'h1234_5A5A, 32'hABCD_0F0F, 16'h1234, 16'hABCD};
        vt[1] = '{8,  32'h0000_00A5, 32'h0000_003C, 16'hA500, 16'h3C00};
        vt[2] = '{16, 32'h0000_8000, 32'h0000_7FFF, 16'h8000, 16'h7FFF};
        vt[3] = '{24, 32'h00FE_DCBA, 32'h0000_0001, 16'hFEDC, 16'h0000};
        vt[4] = '{17, 32'h0001_2345, 32'h0000_0003, 16'h91A2, 16'h0001};
        vt[5] = '{16, 32'h0000_FFFF, 32'h0000_0000, 16'hFFFF, 16'h0000};

        Enable = 1; SampleReady = 1;
        repeat (3) tick();
        check("rst_valid", SampleValid, 0);
        check("rst_left", SampleLeft, 0);
        check("rst_right", SampleRight, 0);
        check("rst_overrun", Overrun, 0);
        Reset = 0;
        tick();

        // 32-bit slots, one aligning frame then three delivered pairs
        rise_q.delete(); rcomp_q.delete();
        mon_en = 1;
        for (int i = 0; i < 4; i++) push_frame(vt[0].l, vt[0].r, 32);
        for (int i = 0; i < 3; i++) exp_q.push_back('{16'h1234, 16'hABCD});
        play();
        settle_empty("t1_pairs");
        check("t1_pulses", rise_q.size(), 3);
        if (rise_q.size() == 3 && rcomp_q.size() == 4)
            for (int i = 0; i < 3; i++) check("t1_latency", rise_q[i] - rcomp_q[i+1], 3);

        // stream starts mid-right-word
        do_reset(); mon_en = 1;
        push_word(1'b1, 32'h0000_03A7, 10);
        push_frame(vt[1].l, vt[1].r, 8);
        push_frame(vt[2].l, vt[2].r, 16);
        exp_q.push_back('{vt[1].el, vt[1].er});
        exp_q.push_back('{vt[2].el, vt[2].er});
        play();
        settle_empty("t2_pairs");

        for (int i = 0; i < 6; i++) begin
            do_reset(); mon_en = 1;
            push_frame($urandom, $urandom, vt[i].slot);
            push_frame(vt[i].l, vt[i].r, vt[i].slot);
            exp_q.push_back('{vt[i].el, vt[i].er});
            play();
            settle_empty("vec_pairs");
        end

        // random slots and data with a randomly stalling consumer
        do_reset(); mon_en = 1;
        push_frame($urandom, $urandom, $urandom_range(8, 32));
        for (int i = 0; i < 12; i++) begin
            int s; logic [31:0] l, r;
            s = $urandom_range(8, 32); l = $urandom; r = $urandom;
            push_frame(l, r, s);
            exp_q.push_back('{top16(l, s), top16(r, s)});
        end
        rdone = 0;
        fork
            begin play(); rdone = 1; end
            begin while (!rdone) begin SampleReady = 1'($urandom_range(0, 1)); tick(); end end
        join
        SampleReady = 1;
        settle_empty("rand_pairs");
        check("rand_overrun", Overrun, 0);

        // consumer stalled across three frames
        do_reset(); SampleReady = 0;
        push_frame(32'h9999, 32'h6666, 16);
        push_frame(32'h0001, 32'h0002, 16);
        push_frame(32'h0003, 32'h0004, 16);
        push_frame(32'h0005, 32'h0006, 16);
        play();
        repeat (8) tick();
        check("t4_valid", SampleValid, 1);
        check("t4_left", SampleLeft, 16'h0001);
        check("t4_right", SampleRight, 16'h0002);
        check("t4_overrun", Overrun, 1);
        OverrunClear = 1; tick(); OverrunClear = 0;
        check("t4_ovr_clear", Overrun, 0);
        check("t4_valid_hold", SampleValid, 1);
        exp_q.push_back('{16'h0001, 16'h0002});
        exp_q.push_back('{16'h0007, 16'h0008});
        mon_en = 1; SampleReady = 1;
        push_frame(32'h0007, 32'h0008, 16);
        play();
        settle_empty("t4_resume");
        check("t4_overrun_after", Overrun, 0);

        // ready rises exactly in the cycle the next pair lands
        do_reset(); SampleReady = 0;
        push_frame(32'h5A5A, 32'hA5A5, 16);
        push_frame(32'h1111, 32'h2222, 16);
        push_frame(32'h3333, 32'h4444, 16);
        play();
        check("t5_held_left", SampleLeft, 16'h1111);
        for (int n = 0; n < 10 && cyc < last_e0 + 2; n++) tick();
        check("t5_align_cycle", cyc, last_e0 + 2);
        SampleReady = 1;
        tick();
        SampleReady = 0;
        check("t5_valid", SampleValid, 1);
        check("t5_left", SampleLeft, 16'h3333);
        check("t5_right", SampleRight, 16'h4444);
        check("t5_overrun", Overrun, 0);

        // Enable dropped mid-left-word
        do_reset(); SampleReady = 0;
        push_frame(32'h1234, 32'h4321, 16);
        push_frame(32'h0F0F, 32'hF0F0, 16);
        push_word(1'b0, 32'h1357 >> 10, 6);
        play();
        check("t6_valid_before", SampleValid, 1);
        Enable = 0; tick();
        check("t6_en_valid", SampleValid, 0);
        check("t6_en_left_hold", SampleLeft, 16'h0F0F);
        Enable = 1; tick();
        mon_en = 1; SampleReady = 1;
        push_word(1'b0, 32'h1357, 10);
        push_word(1'b1, 32'h2468, 16);
        push_frame(32'h7E57, 32'h0BAD, 16);
        exp_q.push_back('{16'h7E57, 16'h0BAD});
        play();
        settle_empty("t6_en_resume");

        // Reset pulsed mid-left-word
        mon_en = 0; SampleReady = 0;
        push_frame(32'h1001, 32'h2002, 16);
        push_word(1'b0, 32'h4321 >> 8, 8);
        play();
        repeat (4) tick();
        check("t6_rst_valid_before", SampleValid, 1);
        Reset = 1; #1;
        check("t6_rst_valid", SampleValid, 0);
        check("t6_rst_left", SampleLeft, 0);
        tick(); Reset = 0; tick();
        mon_en = 1; SampleReady = 1;
        push_word(1'b0, 32'h4321, 8);
        push_word(1'b1, 32'h8765, 16);
        push_frame(32'h0C0C, 32'h3030, 16);
        exp_q.push_back('{16'h0C0C, 16'h3030});
        play();
        settle_empty("t6_rst_resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
